// File: rtl/cdb_writeback.sv
// Common data bus writeback: per-unit result queues, fixed-priority arbitration (div > mul > int/ls toggle).
// Latency 1 cycle from *_done to cdb_*; losers queue locally, and a result arriving at a full, non-winning queue is dropped.
module cdb_writeback #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6,
    parameter int Q_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               div_done,
    input  logic [TAG_W-1:0]                   div_tag,
    input  logic [DATA_W-1:0]                  div_data,
    input  logic                               mul_done,
    input  logic [TAG_W-1:0]                   mul_tag,
    input  logic [DATA_W-1:0]                  mul_data,
    input  logic                               int_done,
    input  logic [TAG_W-1:0]                   int_tag,
    input  logic [DATA_W-1:0]                  int_data,
    input  logic                               ls_done,
    input  logic [TAG_W-1:0]                   ls_tag,
    input  logic [DATA_W-1:0]                  ls_data,
    output logic                               cdb_valid,
    output logic [TAG_W-1:0]                   cdb_tag,
    output logic [DATA_W-1:0]                  cdb_data,
    output logic [1:0]                         cdb_src,
    output logic                               collision,
    output logic                               overflow,
    output logic [$clog2(4*Q_DEPTH+1)-1:0]     pending
);

    localparam int PW     = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CW     = $clog2(Q_DEPTH + 1);
    localparam int PEND_W = $clog2(4*Q_DEPTH + 1);

    // Source index matches the cdb_src encoding: 0 int, 1 ls, 2 mul, 3 div.
    logic [3:0]        in_done;
    logic [TAG_W-1:0]  in_tag  [4];
    logic [DATA_W-1:0] in_data [4];

    assign in_done    = {div_done, mul_done, ls_done, int_done};
    assign in_tag[0]  = int_tag;
    assign in_tag[1]  = ls_tag;
    assign in_tag[2]  = mul_tag;
    assign in_tag[3]  = div_tag;
    assign in_data[0] = int_data;
    assign in_data[1] = ls_data;
    assign in_data[2] = mul_data;
    assign in_data[3] = div_data;

    logic [TAG_W-1:0]  q_tag  [4][Q_DEPTH];
    logic [DATA_W-1:0] q_data [4][Q_DEPTH];
    logic [PW-1:0]     rd_ptr [4];
    logic [PW-1:0]     wr_ptr [4];
    logic [CW-1:0]     cnt    [4];
    logic              rr;

    logic [3:0]        q_nonempty;
    logic [3:0]        q_full;
    logic [3:0]        cand;
    logic [3:0]        pop;
    logic [3:0]        push;
    logic [3:0]        drop;
    logic              win_vld;
    logic [1:0]        win_src;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;
    logic              rr_flip;
    logic              multi_done;
    logic [CW-1:0]     cnt_nxt [4];
    logic [PEND_W-1:0] pend_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(Q_DEPTH - 1))
            return '0;
        return p + PW'(1);
    endfunction

    always_comb begin
        q_nonempty = '0;
        q_full     = '0;
        cand       = '0;
        pop        = '0;
        push       = '0;
        drop       = '0;
        pend_nxt   = '0;
        for (int i = 0; i < 4; i++) begin
            q_nonempty[i] = (cnt[i] != '0);
            q_full[i]     = (cnt[i] == CW'(Q_DEPTH));
            // An empty queue lets its incoming result compete directly.
            cand[i]       = q_nonempty[i] | in_done[i];
        end

        win_vld = |cand;
        if (cand[3])
            win_src = 2'd3;
        else if (cand[2])
            win_src = 2'd2;
        else if (cand[0] && cand[1])
            win_src = rr ? 2'd1 : 2'd0;
        else if (cand[1])
            win_src = 2'd1;
        else
            win_src = 2'd0;
        rr_flip = cand[0] & cand[1] & ~cand[2] & ~cand[3];

        if (q_nonempty[win_src]) begin
            win_tag  = q_tag[win_src][rd_ptr[win_src]];
            win_data = q_data[win_src][rd_ptr[win_src]];
        end else begin
            win_tag  = in_tag[win_src];
            win_data = in_data[win_src];
        end

        for (int i = 0; i < 4; i++) begin
            logic won;
            logic want;
            won        = win_vld && (win_src == 2'(i));
            pop[i]     = won & q_nonempty[i];
            want       = in_done[i] & ~(won & ~q_nonempty[i]);
            // A full queue still takes a new entry when its head leaves this cycle.
            push[i]    = want & (~q_full[i] | pop[i]);
            drop[i]    = want & q_full[i] & ~pop[i];
            cnt_nxt[i] = cnt[i] + CW'(push[i]) - CW'(pop[i]);
            pend_nxt   = pend_nxt + PEND_W'(cnt_nxt[i]);
        end

        multi_done = ((in_done & (in_done - 4'd1)) != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            rr        <= 1'b0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= 2'd0;
            collision <= 1'b0;
            overflow  <= 1'b0;
            pending   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_nxt[i];
                if (push[i])
                    wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                if (pop[i])
                    rd_ptr[i] <= ptr_inc(rd_ptr[i]);
            end
            if (rr_flip)
                rr <= ~rr;
            cdb_valid <= win_vld;
            cdb_tag   <= win_vld ? win_tag  : '0;
            cdb_data  <= win_vld ? win_data : '0;
            cdb_src   <= win_vld ? win_src  : 2'd0;
            collision <= multi_done;
            overflow  <= overflow | (|drop);
            pending   <= pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst && push[i]) begin
                q_tag[i][wr_ptr[i]]  <= in_tag[i];
                q_data[i][wr_ptr[i]] <= in_data[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_writeback.sv
// Directed table-driven bench for cdb_writeback with hand-written reset and full-queue sequences.
module tb_cdb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_done, mul_done, int_done, ls_done;
    logic [5:0]  div_tag, mul_tag, int_tag, ls_tag;
    logic [31:0] div_data, mul_data, int_data, ls_data;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [1:0]  cdb_src;
    logic        collision;
    logic        overflow;
    logic [3:0]  pending;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cdb_writeback #(.DATA_W(32), .TAG_W(6), .Q_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .div_done(div_done), .div_tag(div_tag), .div_data(div_data),
        .mul_done(mul_done), .mul_tag(mul_tag), .mul_data(mul_data),
        .int_done(int_done), .int_tag(int_tag), .int_data(int_data),
        .ls_done(ls_done),   .ls_tag(ls_tag),   .ls_data(ls_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_src(cdb_src), .collision(collision), .overflow(overflow),
        .pending(pending)
    );

    typedef struct {
        logic       r;
        logic [3:0] d;     // bit0 int, bit1 ls, bit2 mul, bit3 div
        logic [5:0] ti, tl, tm, td;
        logic       ev;
        logic [5:0] et;
        logic [1:0] es;
        logic [3:0] ep;
        logic       ec, eo;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mk_data(input logic [1:0] s, input logic [5:0] t);
        return 32'hD000_0000 | (32'(s) << 12) | 32'(t);
    endfunction

    function automatic vec_t mkv(input logic r, input logic [3:0] d,
                                 input logic [5:0] ti, input logic [5:0] tl,
                                 input logic [5:0] tm, input logic [5:0] td,
                                 input logic ev, input logic [5:0] et, input logic [1:0] es,
                                 input logic [3:0] ep, input logic ec, input logic eo);
        vec_t v;
        v.r = r; v.d = d; v.ti = ti; v.tl = tl; v.tm = tm; v.td = td;
        v.ev = ev; v.et = et; v.es = es; v.ep = ep; v.ec = ec; v.eo = eo;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [3:0] d,
                         input logic [5:0] ti, input logic [5:0] tl,
                         input logic [5:0] tm, input logic [5:0] td);
        rst      = r;
        int_done = d[0]; ls_done = d[1]; mul_done = d[2]; div_done = d[3];
        int_tag  = ti;   ls_tag  = tl;   mul_tag  = tm;   div_tag  = td;
        int_data = mk_data(2'd0, ti);
        ls_data  = mk_data(2'd1, tl);
        mul_data = mk_data(2'd2, tm);
        div_data = mk_data(2'd3, td);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_out(input string nm, input logic ev, input logic [5:0] et,
                              input logic [1:0] es, input logic [3:0] ep,
                              input logic ec, input logic eo);
        chk({nm, ".valid"},     32'(cdb_valid), 32'(ev));
        chk({nm, ".tag"},       32'(cdb_tag),   ev ? 32'(et) : 32'd0);
        chk({nm, ".data"},      cdb_data,       ev ? mk_data(es, et) : 32'd0);
        chk({nm, ".src"},       32'(cdb_src),   ev ? 32'(es) : 32'd0);
        chk({nm, ".pending"},   32'(pending),   32'(ep));
        chk({nm, ".collision"}, 32'(collision), 32'(ec));
        chk({nm, ".overflow"},  32'(overflow),  32'(eo));
    endtask

    initial begin
        // Four-way collision drains div, mul, int, ls; rr ends at 1.
        vecs.push_back(mkv(0, 4'b1111, 3, 4, 2, 1,   1, 1, 3, 3, 1, 0));
        vecs.push_back(mkv(0, 4'b0000, 0, 0, 0, 0,   1, 2, 2, 2, 0, 0));
        vecs.push_back(mkv(0, 4'b0000, 0, 0, 0, 0,   1, 3, 0, 1, 0, 0));
        vecs.push_back(mkv(0, 4'b0000, 0, 0, 0, 0,   1, 4, 1, 0, 0, 0));
        // Reset to bring rr back to 0, then int/ls alternation.
        vecs.push_back(mkv(1, 4'b0000, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(0, 4'b0011, 10, 20, 0, 0, 1, 10, 0, 1, 1, 0));
        vecs.push_back(mkv(0, 4'b0011, 11, 21, 0, 0, 1, 20, 1, 2, 1, 0));
        vecs.push_back(mkv(0, 4'b0000, 0, 0, 0, 0,   1, 11, 0, 1, 0, 0));
        vecs.push_back(mkv(0, 4'b0000, 0, 0, 0, 0,   1, 21, 1, 0, 0, 0));
        // div streams for 6 cycles; mul keeps 40,41 and drops 42..45.
        for (int k = 0; k < 6; k++)
            vecs.push_back(mkv(0, 4'b1100, 0, 0, 6'(40 + k), 6'(30 + k),
                               1, 6'(30 + k), 3, (k == 0) ? 4'd1 : 4'd2, 1, (k >= 2)));
        vecs.push_back(mkv(0, 4'b0000, 0, 0, 0, 0,   1, 40, 2, 1, 0, 1));
        vecs.push_back(mkv(0, 4'b0000, 0, 0, 0, 0,   1, 41, 2, 0, 0, 1));
        vecs.push_back(mkv(0, 4'b0000, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1));

        // Reset state.
        drive(1, 4'b0000, 0, 0, 0, 0);
        tick();
        tick();
        expect_out("reset", 0, 0, 0, 0, 0, 0);

        // Single int result, no contention.
        drive(0, 4'b0001, 5, 0, 0, 0);
        int_data = 32'hA5A5_0001;
        tick();
        chk("single.valid",     32'(cdb_valid), 32'd1);
        chk("single.tag",       32'(cdb_tag),   32'd5);
        chk("single.data",      cdb_data,       32'hA5A5_0001);
        chk("single.src",       32'(cdb_src),   32'd0);
        chk("single.pending",   32'(pending),   32'd0);
        chk("single.collision", 32'(collision), 32'd0);
        drive(0, 4'b0000, 0, 0, 0, 0);
        tick();
        chk("single_next.valid", 32'(cdb_valid), 32'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].d, vecs[i].ti, vecs[i].tl, vecs[i].tm, vecs[i].td);
            tick();
            expect_out($sformatf("row%0d", i), vecs[i].ev, vecs[i].et, vecs[i].es,
                       vecs[i].ep, vecs[i].ec, vecs[i].eo);
        end

        // Reset clears the sticky overflow.
        drive(1, 4'b0000, 0, 0, 0, 0);
        tick();
        expect_out("rst2", 0, 0, 0, 0, 0, 0);

        // Fill mul queue behind div, then pop and push the full queue in one cycle.
        drive(0, 4'b1100, 0, 0, 60, 50);
        tick();
        expect_out("full_a", 1, 50, 3, 1, 1, 0);
        drive(0, 4'b1100, 0, 0, 61, 51);
        tick();
        expect_out("full_b", 1, 51, 3, 2, 1, 0);
        drive(0, 4'b0100, 0, 0, 62, 0);
        tick();
        expect_out("full_c", 1, 60, 2, 2, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0);
        tick();
        expect_out("full_d", 1, 61, 2, 1, 0, 0);
        tick();
        expect_out("full_e", 1, 62, 2, 0, 0, 0);

        // Reset with three entries queued; done inputs during reset are ignored.
        drive(0, 4'b1111, 3, 4, 2, 1);
        tick();
        expect_out("rstq_a", 1, 1, 3, 3, 1, 0);
        drive(1, 4'b1111, 13, 14, 12, 11);
        tick();
        expect_out("rstq_b", 0, 0, 0, 0, 0, 0);
        drive(0, 4'b0010, 0, 7, 0, 0);
        tick();
        expect_out("rstq_c", 1, 7, 1, 0, 0, 0);
        drive(0, 4'b0000, 0, 0, 0, 0);
        tick();
        expect_out("rstq_d", 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
